// File: rtl/crossing_request_ctrl.sv
// rtl/crossing_request_ctrl.sv - pedestrian request latch and phase-change timer; PED_REQ_EN enables the button path
module crossing_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MIN_GREEN       = 5,
  parameter int unsigned GREEN_MAX       = 20,
  parameter int unsigned PED_FLASH       = 10,
  parameter int unsigned YELLOW_TICKS    = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       btn1,
  input  logic       btn2,
  input  logic [3:0] state_in,
  output logic       change,
  output logic       req1_pending,
  output logic       req2_pending,
  output logic [7:0] wait_count
);

  typedef enum logic {
    DWELL  = 1'b0,
    CHANGE = 1'b1
  } fsm_t;

  localparam logic [7:0] MIN_GREEN_T = 8'(MIN_GREEN);
  localparam logic [7:0] GREEN_MAX_T = 8'(GREEN_MAX);
  localparam logic [7:0] PED_FLASH_T = 8'(PED_FLASH);
  localparam logic [7:0] YELLOW_T    = 8'(YELLOW_TICKS);

  logic [3:0] state_prev_q, state_prev_d;
  logic [7:0] dwell_q, dwell_d;
  fsm_t       fsm_q, fsm_d;
  logic       change_q, change_d;
  logic       req1_q, req1_d;
  logic       req2_q, req2_d;

  logic       state_changed;
  logic       state_illegal;
  logic       thresh_met;
  logic [7:0] threshold;

`ifdef PED_REQ_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      btn_raw;
  logic [1:0]      sync0_q, sync0_d;
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      rise;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  assign btn_raw = {btn2, btn1};

  // Two-stage synchronizer, then accept a new level only after it has held for the full debounce window
  always_comb begin
    sync0_d = btn_raw;
    sync1_d = sync0_q;
    level_d = level_q;
    rise    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync1_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync1_q[i];
          rise[i]    = sync1_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Synchronizer and debounce state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync0_q <= 2'b00;
      sync1_q <= 2'b00;
      level_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      level_q <= level_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Latch a press unless its own crossing is already being served; serving the crossing clears it
  always_comb begin
    req1_d = req1_q;
    req2_d = req2_q;
    if (rise[0] && (state_in != 4'd3) && (state_in != 4'd4)) begin
      req1_d = 1'b1;
    end
    if (state_in == 4'd3) begin
      req1_d = 1'b0;
    end
    if (rise[1] && (state_in != 4'd0) && (state_in != 4'd1)) begin
      req2_d = 1'b1;
    end
    if (state_in == 4'd0) begin
      req2_d = 1'b0;
    end
  end
`else
  logic unused_btns;
  assign unused_btns = btn1 ^ btn2;

  // Button path absent: requests never latch, so green always runs to GREEN_MAX
  always_comb begin
    req1_d = 1'b0;
    req2_d = 1'b0;
  end
`endif

  // Dwell threshold for the current light state; unknown states count as already expired
  always_comb begin
    threshold     = 8'd0;
    state_illegal = 1'b0;
    case (state_in)
      4'd0:       threshold = req1_q ? MIN_GREEN_T : GREEN_MAX_T;
      4'd3:       threshold = req2_q ? MIN_GREEN_T : GREEN_MAX_T;
      4'd1, 4'd4: threshold = PED_FLASH_T;
      4'd2, 4'd5: threshold = YELLOW_T;
      default:    state_illegal = 1'b1;
    endcase
  end

  assign state_changed = (state_in != state_prev_q);
  assign thresh_met    = state_illegal || (dwell_q >= threshold);

  // Dwell counter restarts on every light-state change and saturates instead of wrapping
  always_comb begin
    state_prev_d = state_in;
    dwell_d      = dwell_q;
    if (state_changed) begin
      dwell_d = 8'd0;
    end else if (tick && (dwell_q != 8'hFF)) begin
      dwell_d = dwell_q + 8'd1;
    end
  end

  // Change request: raised once the phase has dwelt long enough, held until the light FSM moves
  always_comb begin
    fsm_d    = fsm_q;
    change_d = change_q;
    if (fsm_q == DWELL) begin
      if (state_illegal || (!state_changed && thresh_met)) begin
        fsm_d    = CHANGE;
        change_d = 1'b1;
      end else begin
        change_d = 1'b0;
      end
    end else begin
      if (state_changed) begin
        fsm_d    = DWELL;
        change_d = 1'b0;
      end else begin
        change_d = 1'b1;
      end
    end
  end

  // Core state registers, including the FSM and its registered change output
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_prev_q <= 4'd0;
      dwell_q      <= 8'd0;
      fsm_q        <= DWELL;
      change_q     <= 1'b0;
      req1_q       <= 1'b0;
      req2_q       <= 1'b0;
    end else begin
      state_prev_q <= state_prev_d;
      dwell_q      <= dwell_d;
      fsm_q        <= fsm_d;
      change_q     <= change_d;
      req1_q       <= req1_d;
      req2_q       <= req2_d;
    end
  end

  // Ticks left before a change is allowed
  always_comb begin
    wait_count = 8'd0;
    if (dwell_q < threshold) begin
      wait_count = threshold - dwell_q;
    end
  end

  assign change       = change_q;
  assign req1_pending = req1_q;
  assign req2_pending = req2_q;

endmodule
